fsqrt_ctrl: RTL
===============

Name: fsqrt_ctrl

Overview:
- Single-precision IEEE-754 square-root sequencer that wraps the team's 32-bit Newton fraction square-root core.
- Upstream side: unpacks operand `a`, resolves special cases, aligns the fraction to `.1xx…` or `.01xx…` by exponent parity, and issues a 1-cycle `core_start`.
- Downstream side: captures `core_q` on `core_ready`, then rounds and packs the float result.
- Sits in the FPU execute path between ID-stage issue and FP register writeback.

Parameters:
- none; format is fixed at binary32 and constants live in `fsqrt_pkg`.

Ports:
- `clock` | in | 1 | system clock, rising edge.
- `resetn` | in | 1 | reset, asynchronous, active-low.
- `a` | in | 32 | operand, IEEE binary32; sampled when accepted.
- `start_in` | in | 1 | request, issued as `is_fsqrt & ~busy`.
- `rm` | in | 2 | rounding mode, sampled with `a`: 00 RNE, 01 RZ, 10 RUP, 11 RDN.
- `core_d` | out | 32 | radicand to the core, held stable in ISSUE and WAIT.
- `core_start` | out | 1 | 1-cycle start pulse to the core.
- `core_ready` | in | 1 | core 1-cycle done pulse.
- `core_q` | in | 32 | core root, `.1xxx…`; bit 0 carries the core's sticky OR.
- `s` | out | 32 | packed result; registered and held until the next result.
- `invalid` | out | 1 | invalid-operation flag, valid with `ready`.
- `inexact` | out | 1 | inexact flag, valid with `ready`.
- `busy` | out | 1 | high in every state except IDLE.
- `ready` | out | 1 | 1-cycle result-valid pulse.

Behaviour:
- Reset: state IDLE; `s`, `invalid`, `inexact`, `ready`, `busy`, `core_start` all 0. Reset mid-operation aborts with no `ready` pulse; the core shares `resetn`.
- FSM states: IDLE, ISSUE, WAIT, ROUND, DONE.
- IDLE: `start_in` at edge T latches `a` and `rm`; next state ISSUE. `start_in` is ignored in every other state.
- ISSUE (T+1):
  - Special operands go straight to DONE, with `s`, `invalid` and `inexact` registered at this edge.
  - Otherwise `core_start` = 1 for this cycle only, `core_d` is driven, and the next state is WAIT.
- Special cases (all have `inexact` = 0, `core_start` never asserted, `ready` at T+2):
  - NaN input → 0x7FC00000; `invalid` = 1 only if signalling (`a[22]` = 0).
  - ±0 → ±0.
  - Denormal → signed zero (flush-to-zero).
  - +inf → 0x7F800000.
  - Negative nonzero (including −inf) → 0x7FC00000 with `invalid` = 1.
- Alignment for normal operands, with biased exponent `e`:
  - `e` odd: `core_d` = {2'b01, f, 7'b0}; result exponent = (e+127)>>1.
  - `e` even: `core_d` = {1'b1, f, 8'b0}; result exponent = (e+126)>>1.
- WAIT: on `core_ready`, latch `core_q`; next state ROUND. `core_ready` in any other state is ignored. There is no timeout.
- ROUND: result value bits are `mant` = `q[30:8]`, `lsb` = `q[8]`, guard `g` = `q[7]`, sticky `st` = |`q[6:0]`.
  - Increment condition: RNE `g & (st | lsb)`; RZ and RDN never; RUP `g | st` (the result is positive).
  - If the increment carries out of the mantissa, clear the mantissa and add 1 to the exponent.
  - `inexact` = `g | st`; `invalid` = 0; sign = 0.
  - `s`, `inexact` and `invalid` are registered at this edge; next state DONE.
- DONE: `ready` = 1 for exactly one cycle; next state IDLE unconditionally.
  - `busy` falls on the same edge `ready` falls, so a new `start_in` is accepted in the cycle after DONE.
- Latency: specials 2 cycles; normal operands = core latency + 3 (ISSUE, ROUND, DONE).

Decomposition:
- `fsqrt_pkg`: state enum, rounding-mode encodings, QNAN = 32'h7FC00000, PINF = 32'h7F800000, BIAS = 127.
- One combinational sub-module, `fsqrt_round`:
  - inputs `q[31:0]`, `exp[7:0]`, `rm`;
  - outputs packed `s[31:0]` and `inexact`.
  - It is instantiated in ROUND.
- The FSM, unpacking, special-case detection and alignment stay in `fsqrt_ctrl`.
- The bench instantiates `fsqrt_ctrl` with the real Newton core.

Test Plan:
- `a` = 0x40800000 (4.0), RNE → `s` = 0x40000000; `invalid` = 0; `inexact` = 0; exactly one `core_start`.
- `a` = 0x40000000 (2.0):
  - RNE → `s` = 0x3FB504F3, `inexact` = 1;
  - RUP → `s` = 0x3FB504F4;
  - RZ → `s` = 0x3FB504F3.
- Specials, each with `ready` at T+2 and `core_start` never high:
  - 0xBF800000 → 0x7FC00000, `invalid` = 1;
  - 0x7F800000 → 0x7F800000;
  - 0x80000000 → 0x80000000;
  - 0x00000001 → 0x00000000;
  - 0x7F800001 (sNaN) → 0x7FC00000, `invalid` = 1.
- `a` = 0x3F800000 (1.0) → `s` = 0x3F800000, `inexact` = 0. Check that `core_d` = 0x40000000 (odd-exponent path).
- `start_in` pulsed while `busy` with a different `a` → ignored; the first result is unchanged and only one `ready` pulse occurs.
- `resetn` low during WAIT → all outputs 0 next cycle with no `ready` pulse; a fresh 4.0 request then completes correctly.

Source files
------------

// File: rtl/fsqrt_pkg.sv
// Shared constants and types for the binary32 square-root sequencer.
package fsqrt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RZ  = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam int          BIAS = 127;

    // Anything the core must not see: NaN/inf, zero/denormal, or negative.
    function automatic logic is_special(input logic [31:0] x);
        return x[31] | (x[30:23] == 8'hFF) | (x[30:23] == 8'h00);
    endfunction

endpackage

// File: rtl/fsqrt_round.sv
// Rounds the core root (.1xxx with sticky in bit 0) and packs a positive binary32.
module fsqrt_round
    import fsqrt_pkg::*;
(
    input  logic [31:0] q,
    input  logic [7:0]  exp,
    input  logic [1:0]  rm,
    output logic [31:0] s,
    output logic        inexact
);

    logic        w_g;
    logic        w_st;
    logic        w_inc;
    logic [23:0] w_sum;

    always_comb begin
        w_g  = q[7];
        w_st = |q[6:0];
        case (rm)
            RM_RNE:  w_inc = w_g & (w_st | q[8]);
            RM_RUP:  w_inc = w_g | w_st;
            default: w_inc = 1'b0;
        endcase
        // Hidden bit q[31] is always 1, so bit 23 of the sum drops only on carry-out.
        w_sum   = q[31:8] + {23'b0, w_inc};
        s       = {1'b0, exp + {7'b0, ~w_sum[23]}, w_sum[22:0]};
        inexact = w_g | w_st;
    end

endmodule

// File: rtl/fsqrt_ctrl.sv
// binary32 sqrt sequencer: special-case filter, radicand alignment, core handshake, rounding.
module fsqrt_ctrl
    import fsqrt_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] a,
    input  logic        start_in,
    input  logic [1:0]  rm,
    output logic [31:0] core_d,
    output logic        core_start,
    input  logic        core_ready,
    input  logic [31:0] core_q,
    output logic [31:0] s,
    output logic        invalid,
    output logic        inexact,
    output logic        busy,
    output logic        ready
);

    state_t      r_state;
    logic [31:0] r_a;
    logic [1:0]  r_rm;
    logic [31:0] r_q;
    logic [31:0] r_core_d;
    logic [7:0]  r_exp;
    logic [31:0] r_s;
    logic        r_core_start;
    logic        r_invalid;
    logic        r_inexact;
    logic        r_busy;
    logic        r_ready;

    logic [31:0] w_align;
    logic [7:0]  w_rexp;
    logic [31:0] w_sp_s;
    logic        w_sp_inv;
    logic [31:0] w_rnd_s;
    logic        w_rnd_inexact;

    // Odd e: (e+127)>>1 == (e>>1)+64; even e: (e+126)>>1 == (e>>1)+63.
    always_comb begin
        w_align = a[23] ? {2'b01, a[22:0], 7'b0} : {1'b1, a[22:0], 8'b0};
        w_rexp  = {1'b0, a[30:24]} + 8'((BIAS - 1) / 2) + {7'b0, a[23]};
    end

    always_comb begin
        w_sp_s   = QNAN;
        w_sp_inv = 1'b1;
        if (r_a[30:23] == 8'hFF && r_a[22:0] != 23'b0) begin
            w_sp_inv = ~r_a[22];
        end else if (r_a[30:23] == 8'h00) begin
            w_sp_s   = {r_a[31], 31'b0};
            w_sp_inv = 1'b0;
        end else if (!r_a[31]) begin
            w_sp_s   = PINF;
            w_sp_inv = 1'b0;
        end
    end

    fsqrt_round u_round (
        .q       (r_q),
        .exp     (r_exp),
        .rm      (r_rm),
        .s       (w_rnd_s),
        .inexact (w_rnd_inexact)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_rm         <= '0;
            r_q          <= '0;
            r_core_d     <= '0;
            r_exp        <= '0;
            r_s          <= '0;
            r_core_start <= 1'b0;
            r_invalid    <= 1'b0;
            r_inexact    <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start_in) begin
                    r_a          <= a;
                    r_rm         <= rm;
                    r_core_d     <= w_align;
                    r_exp        <= w_rexp;
                    r_core_start <= ~is_special(a);
                    r_busy       <= 1'b1;
                    r_state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_core_start <= 1'b0;
                    if (is_special(r_a)) begin
                        r_s       <= w_sp_s;
                        r_invalid <= w_sp_inv;
                        r_inexact <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: if (core_ready) begin
                    r_q     <= core_q;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_s       <= w_rnd_s;
                    r_inexact <= w_rnd_inexact;
                    r_invalid <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_d     = r_core_d;
    assign core_start = r_core_start;
    assign s          = r_s;
    assign invalid    = r_invalid;
    assign inexact    = r_inexact;
    assign busy       = r_busy;
    assign ready      = r_ready;

endmodule
